// File: rtl/l1_mem_bridge_pkg.sv
// Local types for the L1 to system bus bridge.
// State encoding, beat counter width, cached beat size.
package l1_mem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_BRESP,
    ST_RESP
  } state_e;

  // Wide enough for any o_a_len value.
  localparam int BEAT_CNT_BITS = 8;

  // Cached bursts always move full 64-bit beats.
  localparam logic [2:0] CACHED_BEAT_SIZE = 3'd3;

endpackage

// File: rtl/river_cfg_pkg.sv
// Shared River CPU configuration constants.
// Memory request type bit positions and address/beat widths.
package river_cfg_pkg;

  localparam int CFG_CPU_ADDR_BITS = 32;

  localparam int REQ_MEM_TYPE_BITS   = 3;
  localparam int REQ_MEM_TYPE_WRITE  = 0;
  localparam int REQ_MEM_TYPE_CACHED = 1;
  localparam int REQ_MEM_TYPE_UNIQUE = 2;

  localparam int L1CACHE_BEAT_BITS  = 64;
  localparam int L1CACHE_LINE_BEATS = 4;

endpackage

// File: rtl/l1_mem_bridge.sv
// L1 cache memory request to burst bus bridge, one transaction in flight.
// Ports: i_req_*/o_req_ready request in; o_resp_* one-cycle response out;
//   o_a_*/i_a_ready address channel; o_w_*/i_w_ready write beats;
//   i_r_* read beats (RDATA only); i_b_* write response (BRESP only).
module l1_mem_bridge
  import river_cfg_pkg::*;
  import l1_mem_bridge_pkg::*;
#(
  parameter int line_beats = L1CACHE_LINE_BEATS
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic                          i_req_path,
  input  logic [REQ_MEM_TYPE_BITS-1:0]  i_req_type,
  input  logic [2:0]                    i_req_size,
  input  logic [CFG_CPU_ADDR_BITS-1:0]  i_req_addr,
  input  logic [8*line_beats-1:0]       i_req_strob,
  input  logic [64*line_beats-1:0]      i_req_data,
  output logic                          o_resp_valid,
  output logic                          o_resp_path,
  output logic [64*line_beats-1:0]      o_resp_data,
  output logic                          o_resp_load_fault,
  output logic                          o_resp_store_fault,
  output logic                          o_a_valid,
  input  logic                          i_a_ready,
  output logic                          o_a_write,
  output logic [CFG_CPU_ADDR_BITS-1:0]  o_a_addr,
  output logic [7:0]                    o_a_len,
  output logic [2:0]                    o_a_size,
  output logic                          o_w_valid,
  input  logic                          i_w_ready,
  output logic [63:0]                   o_w_data,
  output logic [7:0]                    o_w_strb,
  input  logic                          i_r_valid,
  input  logic [63:0]                   i_r_data,
  input  logic                          i_r_err,
  input  logic                          i_b_valid,
  input  logic                          i_b_err
);

  localparam int LINE_BYTES = 8 * line_beats;
  localparam int OFF_BITS   = $clog2(LINE_BYTES);
  localparam int IDX_BITS   = (line_beats > 1) ? $clog2(line_beats) : 1;

  typedef logic [line_beats-1:0][63:0] line_t;
  typedef logic [line_beats-1:0][7:0]  strb_t;

  state_e                         state_q, state_d;
  logic [BEAT_CNT_BITS-1:0]       cnt_q, cnt_d;
  logic                           err_q, err_d;
  line_t                          line_q, line_d;
  logic                           path_q, path_d;
  logic [REQ_MEM_TYPE_BITS-1:0]   type_q, type_d;
  logic [2:0]                     size_q, size_d;
  logic [CFG_CPU_ADDR_BITS-1:0]   addr_q, addr_d;
  strb_t                          strob_q, strob_d;

  logic                           cached;
  logic                           write;
  logic [7:0]                     a_len;
  logic [IDX_BITS-1:0]            beat_idx;
  logic [IDX_BITS-1:0]            uc_idx;
  logic                           last_beat;
  logic                           unused_type;

  assign cached = type_q[REQ_MEM_TYPE_CACHED];
  assign write  = type_q[REQ_MEM_TYPE_WRITE];
  assign a_len  = cached ? 8'(line_beats - 1) : 8'd0;

  // The unique hint only matters to coherent fabrics.
  assign unused_type = type_q[REQ_MEM_TYPE_UNIQUE];

  assign beat_idx  = cnt_q[IDX_BITS-1:0];
  assign last_beat = (cnt_q == a_len);

  // Uncached accesses live in the line word selected by the address.
  generate
    if (line_beats > 1) begin : g_idx
      assign uc_idx = addr_q[IDX_BITS+2:3];
    end else begin : g_idx1
      assign uc_idx = '0;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      line_q  <= '0;
      path_q  <= 1'b0;
      type_q  <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      strob_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      line_q  <= line_d;
      path_q  <= path_d;
      type_q  <= type_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      strob_q <= strob_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    line_d  = line_q;
    path_d  = path_q;
    type_d  = type_q;
    size_d  = size_q;
    addr_d  = addr_q;
    strob_d = strob_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          path_d  = i_req_path;
          type_d  = i_req_type;
          size_d  = i_req_size;
          addr_d  = i_req_addr;
          strob_d = i_req_strob;
          line_d  = i_req_data;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_a_ready) begin
          cnt_d   = '0;
          state_d = write ? ST_WDATA : ST_RDATA;
        end
      end
      ST_WDATA: begin
        if (i_w_ready) begin
          if (last_beat) begin
            state_d = ST_BRESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RDATA: begin
        if (i_r_valid) begin
          // Uncached data is mirrored so any word select sees it.
          if (cached) begin
            line_d[beat_idx] = i_r_data;
          end else begin
            line_d = {line_beats{i_r_data}};
          end
          err_d = err_q | i_r_err;
          if (last_beat) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_BRESP: begin
        if (i_b_valid) begin
          err_d   = i_b_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_req_ready = (state_q == ST_IDLE);

  assign o_a_valid = (state_q == ST_ADDR);
  assign o_a_write = write;
  assign o_a_addr  = cached
                   ? {addr_q[CFG_CPU_ADDR_BITS-1:OFF_BITS],
                      {OFF_BITS{1'b0}}}
                   : addr_q;
  assign o_a_len   = a_len;
  assign o_a_size  = cached ? CACHED_BEAT_SIZE : size_q;

  assign o_w_valid = (state_q == ST_WDATA);
  assign o_w_data  = cached ? line_q[beat_idx] : line_q[uc_idx];
  assign o_w_strb  = cached ? 8'hFF : strob_q[uc_idx];

  assign o_resp_valid       = (state_q == ST_RESP);
  assign o_resp_path        = path_q;
  assign o_resp_data        = line_q;
  assign o_resp_load_fault  = o_resp_valid & err_q & ~write;
  assign o_resp_store_fault = o_resp_valid & err_q & write;

endmodule

// File: tb/tb_l1_mem_bridge.sv
// Scoreboard bench for l1_mem_bridge.
// Random bus timing, directed corner cases and random transactions.
module tb_l1_mem_bridge;

  localparam int LB = 4;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_req_valid;
  logic           o_req_ready;
  logic           i_req_path;
  logic [2:0]     i_req_type;
  logic [2:0]     i_req_size;
  logic [31:0]    i_req_addr;
  logic [31:0]    i_req_strob;
  logic [255:0]   i_req_data;
  logic           o_resp_valid;
  logic           o_resp_path;
  logic [255:0]   o_resp_data;
  logic           o_resp_load_fault;
  logic           o_resp_store_fault;
  logic           o_a_valid;
  logic           i_a_ready;
  logic           o_a_write;
  logic [31:0]    o_a_addr;
  logic [7:0]     o_a_len;
  logic [2:0]     o_a_size;
  logic           o_w_valid;
  logic           i_w_ready;
  logic [63:0]    o_w_data;
  logic [7:0]     o_w_strb;
  logic           i_r_valid;
  logic [63:0]    i_r_data;
  logic           i_r_err;
  logic           i_b_valid;
  logic           i_b_err;

  always #5 i_clk = ~i_clk;

  l1_mem_bridge #(.line_beats(LB)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_req_path         (i_req_path),
    .i_req_type         (i_req_type),
    .i_req_size         (i_req_size),
    .i_req_addr         (i_req_addr),
    .i_req_strob        (i_req_strob),
    .i_req_data         (i_req_data),
    .o_resp_valid       (o_resp_valid),
    .o_resp_path        (o_resp_path),
    .o_resp_data        (o_resp_data),
    .o_resp_load_fault  (o_resp_load_fault),
    .o_resp_store_fault (o_resp_store_fault),
    .o_a_valid          (o_a_valid),
    .i_a_ready          (i_a_ready),
    .o_a_write          (o_a_write),
    .o_a_addr           (o_a_addr),
    .o_a_len            (o_a_len),
    .o_a_size           (o_a_size),
    .o_w_valid          (o_w_valid),
    .i_w_ready          (i_w_ready),
    .o_w_data           (o_w_data),
    .o_w_strb           (o_w_strb),
    .i_r_valid          (i_r_valid),
    .i_r_data           (i_r_data),
    .i_r_err            (i_r_err),
    .i_b_valid          (i_b_valid),
    .i_b_err            (i_b_err)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } a_exp_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
  } w_exp_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } r_beat_t;

  typedef struct {
    logic         wr;
    logic         path;
    logic [255:0] data;
    logic         lf;
    logic         sf;
  } resp_exp_t;

  a_exp_t    a_q[$];
  w_exp_t    w_q[$];
  r_beat_t   r_q[$];
  logic      b_q[$];
  resp_exp_t resp_q[$];

  int checks = 0;
  int errors = 0;

  logic a_block = 1'b0;
  logic w_toggle = 1'b0;
  int   r_budget = 1000000;
  int   r_allow = 0;
  int   b_allow = 0;
  int   w_left = 0;
  int   r_sent = 0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Expected behaviour derived from the request alone.
  task automatic issue(input logic p, input logic [2:0] typ,
                       input logic [2:0] sz, input logic [31:0] ad,
                       input logic [31:0] st, input logic [255:0] ln,
                       input logic [63:0] rd [4], input logic [3:0] re,
                       input logic be);
    a_exp_t    ea;
    w_exp_t    ew;
    r_beat_t   rb;
    resp_exp_t er;
    logic      cached;
    int        idx;
    int        n;
    logic      acc;
    cached  = typ[1];
    ea.wr   = typ[0];
    ea.addr = cached ? (ad & ~32'(8 * LB - 1)) : ad;
    ea.len  = cached ? 8'(LB - 1) : 8'd0;
    ea.size = cached ? 3'd3 : sz;
    a_q.push_back(ea);
    er.wr   = typ[0];
    er.path = p;
    er.data = '0;
    er.lf   = 1'b0;
    er.sf   = 1'b0;
    if (typ[0]) begin
      if (cached) begin
        for (int i = 0; i < LB; i++) begin
          ew.data = ln[i*64 +: 64];
          ew.strb = 8'hFF;
          w_q.push_back(ew);
        end
      end else begin
        idx = int'(ad >> 3) % LB;
        ew.data = ln[idx*64 +: 64];
        ew.strb = st[idx*8 +: 8];
        w_q.push_back(ew);
      end
      b_q.push_back(be);
      er.sf = be;
    end else begin
      n = cached ? LB : 1;
      for (int i = 0; i < n; i++) begin
        rb.data = rd[i];
        rb.err  = re[i];
        r_q.push_back(rb);
        er.lf = er.lf | re[i];
      end
      for (int i = 0; i < LB; i++) begin
        er.data[i*64 +: 64] = cached ? rd[i] : rd[0];
      end
    end
    resp_q.push_back(er);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b1;
    i_req_path  = p;
    i_req_type  = typ;
    i_req_size  = sz;
    i_req_addr  = ad;
    i_req_strob = st;
    i_req_data  = ln;
    n = 0;
    do begin
      @(negedge i_clk);
      acc = o_req_ready;
      n++;
    end while (!acc && n < 2000);
    if (!acc) fail_now("req_accept_timeout");
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_addr  = $urandom;
    i_req_data  = {8{$urandom}};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (resp_q.size() != 0 && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    if (resp_q.size() != 0) fail_now("resp_timeout");
  endtask

  // Bus side: random handshakes, queued read beats, write responses,
  // plus stray r/b pulses while they must be ignored.
  initial begin
    r_beat_t rb;
    i_a_ready = 1'b0;
    i_w_ready = 1'b0;
    i_r_valid = 1'b0;
    i_r_data  = '0;
    i_r_err   = 1'b0;
    i_b_valid = 1'b0;
    i_b_err   = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (i_rst) begin
        i_a_ready = 1'b0;
        i_w_ready = 1'b0;
        i_r_valid = 1'b0;
        i_r_err   = 1'b0;
        i_b_valid = 1'b0;
        i_b_err   = 1'b0;
      end else begin
        i_a_ready = a_block ? 1'b0 : ($urandom_range(0, 3) != 0);
        i_w_ready = w_toggle ? ~i_w_ready : ($urandom_range(0, 2) != 0);
        i_r_valid = 1'b0;
        i_r_err   = 1'b0;
        i_r_data  = {$urandom, $urandom};
        if (r_allow > 0 && r_budget > 0 && r_q.size() > 0 &&
            $urandom_range(0, 3) != 0) begin
          rb = r_q.pop_front();
          i_r_valid = 1'b1;
          i_r_data  = rb.data;
          i_r_err   = rb.err;
          r_allow--;
          r_budget--;
          r_sent++;
        end else if (r_allow == 0 && $urandom_range(0, 7) == 0) begin
          i_r_valid = 1'b1;
          i_r_err   = 1'b1;
        end
        i_b_valid = 1'b0;
        i_b_err   = 1'b0;
        if (b_allow > 0 && b_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          i_b_valid = 1'b1;
          i_b_err   = b_q.pop_front();
          b_allow--;
        end else if (b_allow == 0 && $urandom_range(0, 7) == 0) begin
          i_b_valid = 1'b1;
          i_b_err   = 1'b1;
        end
      end
    end
  end

  // Monitor: everything sampled at negedge sees exactly what the
  // next rising edge will see.
  initial begin
    a_exp_t    ea;
    w_exp_t    ew;
    resp_exp_t er;
    logic      prev_a_valid;
    logic      prev_a_hs;
    logic [43:0] prev_a_bits;
    logic      prev_resp;
    prev_a_valid = 1'b0;
    prev_a_hs    = 1'b0;
    prev_a_bits  = '0;
    prev_resp    = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_a_valid = 1'b0;
        prev_a_hs    = 1'b0;
        prev_resp    = 1'b0;
      end else begin
        if (o_a_valid) begin
          if (prev_a_valid && !prev_a_hs) begin
            chk("a_stable", {o_a_write, o_a_addr, o_a_len, o_a_size},
                prev_a_bits);
          end
          if (i_a_ready) begin
            if (a_q.size() == 0) begin
              fail_now("a_unexpected");
            end else begin
              ea = a_q.pop_front();
              chk("a_write", o_a_write, ea.wr);
              chk("a_addr", o_a_addr, ea.addr);
              chk("a_len", o_a_len, ea.len);
              chk("a_size", o_a_size, ea.size);
              if (ea.wr) w_left = int'(ea.len) + 1;
              else r_allow = r_allow + int'(ea.len) + 1;
            end
          end
        end
        prev_a_valid = o_a_valid;
        prev_a_hs    = o_a_valid & i_a_ready;
        prev_a_bits  = {o_a_write, o_a_addr, o_a_len, o_a_size};
        if (o_w_valid && i_w_ready) begin
          if (w_q.size() == 0) begin
            fail_now("w_unexpected");
          end else begin
            ew = w_q.pop_front();
            chk("w_data", o_w_data, ew.data);
            chk("w_strb", o_w_strb, ew.strb);
            w_left--;
            if (w_left == 0) b_allow++;
          end
        end
        chk("req_ready_busy",
            o_req_ready & (o_a_valid | o_w_valid | o_resp_valid), 1'b0);
        if (o_resp_valid) begin
          chk("resp_one_cycle", prev_resp, 1'b0);
          if (resp_q.size() == 0) begin
            fail_now("resp_unexpected");
          end else begin
            er = resp_q.pop_front();
            chk("resp_path", o_resp_path, er.path);
            chk("resp_load_fault", o_resp_load_fault, er.lf);
            chk("resp_store_fault", o_resp_store_fault, er.sf);
            if (!er.wr) chk("resp_data", o_resp_data, er.data);
          end
        end
        prev_resp = o_resp_valid;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, o_req_ready, 1'b1);
    chk({tag, "_outs_zero"},
        {o_resp_valid, o_resp_path, o_resp_load_fault, o_resp_store_fault,
         o_a_valid, o_a_write, o_a_addr, o_a_len, o_a_size,
         o_w_valid, o_w_data, o_w_strb}, '0);
    chk({tag, "_resp_data_zero"}, o_resp_data, '0);
  endtask

  initial begin
    logic [63:0]  rd [4];
    logic [255:0] ln;
    logic [2:0]   typ;
    logic [31:0]  st;
    int           base;
    int           n;
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_req_path  = 1'b0;
    i_req_type  = '0;
    i_req_size  = '0;
    i_req_addr  = '0;
    i_req_strob = '0;
    i_req_data  = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs("reset");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Cached read, beats 1..4 land MSW-last.
    rd = '{64'd1, 64'd2, 64'd3, 64'd4};
    issue(1'b0, 3'b010, 3'd0, 32'h80001234, '0, '0, rd, 4'b0, 1'b0);
    wait_idle();

    // Cached write with w_ready toggling.
    w_toggle = 1'b1;
    ln = {64'hDDDD_0000_DDDD_0004, 64'hCCCC_0000_CCCC_0003,
          64'hBBBB_0000_BBBB_0002, 64'hAAAA_0000_AAAA_0001};
    issue(1'b0, 3'b011, 3'd0, 32'h8000_2040, '0, ln, rd, 4'b0, 1'b0);
    wait_idle();
    w_toggle = 1'b0;

    // Uncached sub-word write into word 1.
    issue(1'b0, 3'b001, 3'd2, 32'h10000008, 32'h00000F00, ln, rd,
          4'b0, 1'b0);
    wait_idle();

    // Uncached read on path 1 with a bus error.
    rd = '{64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 64'd0};
    issue(1'b1, 3'b000, 3'd3, 32'h2000_0010, '0, '0, rd, 4'b0001, 1'b0);
    wait_idle();

    // Address channel held off for ten cycles.
    a_block = 1'b1;
    rd = '{64'h11, 64'h22, 64'h33, 64'h44};
    issue(1'b0, 3'b010, 3'd0, 32'h8000_0100, '0, '0, rd, 4'b0, 1'b0);
    repeat (10) @(negedge i_clk);
    chk("stall_req_ready", o_req_ready, 1'b0);
    chk("stall_a_valid", o_a_valid, 1'b1);
    a_block = 1'b0;
    wait_idle();

    // Reset in the middle of a read burst after two beats.
    r_budget = 2;
    base = r_sent;
    rd = '{64'h55, 64'h66, 64'h77, 64'h88};
    issue(1'b1, 3'b010, 3'd0, 32'h8000_0200, '0, '0, rd, 4'b0, 1'b0);
    n = 0;
    while (r_sent < base + 2 && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (r_sent < base + 2) fail_now("mid_burst_timeout");
    repeat (3) @(negedge i_clk);
    chk("mid_burst_no_resp", o_resp_valid, 1'b0);
    i_rst = 1'b1;
    a_q.delete();
    w_q.delete();
    r_q.delete();
    b_q.delete();
    resp_q.delete();
    r_allow  = 0;
    b_allow  = 0;
    w_left   = 0;
    r_budget = 1000000;
    #2;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    rd = '{64'h99, 64'hAA, 64'hBB, 64'hCC};
    issue(1'b0, 3'b010, 3'd0, 32'h8000_0300, '0, '0, rd, 4'b0, 1'b0);
    wait_idle();

    // Random traffic.
    for (int t = 0; t < 80; t++) begin
      typ = 3'($urandom_range(0, 7));
      st  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      ln  = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) rd[i] = {$urandom, $urandom};
      issue(1'($urandom_range(0, 1)), typ, 3'($urandom_range(0, 3)),
            $urandom, st, ln, rd,
            {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)},
            ($urandom_range(0, 3) == 0));
    end
    wait_idle();
    repeat (5) @(negedge i_clk);
    chk("end_idle", o_req_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_mem_bridge.md
L1_MEM_BRIDGE -- requirements
Module: l1_mem_bridge

Interface
REQ-001 Parameter line_beats, default 4: number of 64-bit bus beats per L1 line; L1CACHE_LINE_BITS = 64*line_beats.
REQ-002 i_clk  in  1  single clock, rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_req_valid  in  1  cache-side memory request valid.
REQ-005 o_req_ready  out  1  request accepted this cycle.
REQ-006 i_req_path  in  1  requester id (ctrl/data), echoed on the response.
REQ-007 i_req_type  in  REQ_MEM_TYPE_BITS  bit0 write, bit1 cached, bit2 unique.
REQ-008 i_req_size  in  3  log2 bytes, uncached only.
REQ-009 i_req_addr  in  CFG_CPU_ADDR_BITS  byte address.
REQ-010 i_req_strob  in  L1CACHE_BYTES_PER_LINE  byte enables, uncached write.
REQ-011 i_req_data  in  L1CACHE_LINE_BITS  write line.
REQ-012 o_resp_valid  out  1  one-cycle response pulse.
REQ-013 o_resp_path  out  1  latched i_req_path.
REQ-014 o_resp_data  out  L1CACHE_LINE_BITS  read line.
REQ-015 o_resp_load_fault  out  1  read error.
REQ-016 o_resp_store_fault  out  1  write error.
REQ-017 o_a_valid  out  1  bus address valid.
REQ-018 i_a_ready  in  1  bus address accepted.
REQ-019 o_a_write  out  1  1 = write burst.
REQ-020 o_a_addr  out  CFG_CPU_ADDR_BITS  burst start address.
REQ-021 o_a_len  out  8  beats minus one.
REQ-022 o_a_size  out  3  log2 bytes per beat.
REQ-023 o_w_valid  out  1  write beat valid.
REQ-024 i_w_ready  in  1  write beat accepted.
REQ-025 o_w_data  out  64  write beat data.
REQ-026 o_w_strb  out  8  write beat byte enables.
REQ-027 i_r_valid  in  1  read beat valid; accepted unconditionally in RDATA.
REQ-028 i_r_data  in  64  read beat data.
REQ-029 i_r_err  in  1  read beat error (SLVERR/DECERR).
REQ-030 i_b_valid  in  1  write response valid; accepted unconditionally in BRESP.
REQ-031 i_b_err  in  1  write response error.

Function
REQ-032 FSM states IDLE, ADDR, WDATA, RDATA, BRESP, RESP; o_req_ready=1 only in IDLE; a request is accepted on i_req_valid&o_req_ready, all fields are latched and the FSM enters ADDR; one transaction outstanding.
REQ-033 Cached (type bit1=1): o_a_addr = addr with low log2(L1CACHE_BYTES_PER_LINE) bits zeroed, o_a_len=line_beats-1, o_a_size=3; uncached: o_a_addr=addr, o_a_len=0, o_a_size=i_req_size.
REQ-034 ADDR: o_a_valid and all o_a_* held stable until i_a_ready; then WDATA if write else RDATA; beat counter cleared.
REQ-035 WDATA: cached beat n drives line word n with o_w_strb=8'hFF; uncached drives word addr[4:3] with strb=i_req_strob byte slice of that word; counter increments on i_w_ready; after beat o_a_len goes to BRESP.
REQ-036 RDATA: each i_r_valid writes i_r_data into word[counter] (cached) or into all words (uncached); i_r_err ORed into a sticky error flag; after beat o_a_len goes to RESP.
REQ-037 BRESP: on i_b_valid the error flag is set to i_b_err; FSM enters RESP.
REQ-038 RESP: o_resp_valid=1 for exactly one cycle, load_fault=err&~write, store_fault=err&write; next state IDLE; earliest new accept is the following cycle.
REQ-039 i_r_valid/i_b_valid outside RDATA/BRESP are ignored; an all-zero uncached strobe is still issued as a normal write.

Reset
REQ-040 i_rst asynchronously forces IDLE, zeroes counter, error flag, line buffer and latched fields; all outputs 0 except o_req_ready=1 after reset; a transaction in flight is abandoned without response.

Structure
REQ-041 Package l1_mem_bridge_pkg holds the state enum, beat-counter width and the cached beat-size constant (3); REQ_MEM_TYPE bit positions and line/address widths come from river_cfg_pkg.
REQ-042 Single module, no sub-module.

Verification
REQ-043 Cached read addr 0x80001234 -> a_addr 0x80001220, len 3, size 3; beats 1,2,3,4 -> o_resp_data words {4,3,2,1} (MSW first), one-cycle pulse, load_fault 0.
REQ-044 Cached write words A,B,C,D with i_w_ready toggling every cycle -> 4 beats A..D in order, strb 0xFF, b_err 0 -> store_fault 0.
REQ-045 Uncached write addr 0x10000008, size 2, strob 0x00000F00 -> len 0, o_w_data = word1, o_w_strb 0x0F.
REQ-046 Uncached read path=1 with i_r_err=1 -> o_resp_load_fault 1, o_resp_path 1.
REQ-047 i_a_ready low 10 cycles -> o_a_* stable, o_req_ready 0; then normal completion.
REQ-048 i_rst pulsed in RDATA after 2 beats -> no o_resp_valid, o_req_ready 1 after reset; next request completes correctly.
